// File: rtl/muxn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muxn_pkg
//  Description : Shared types and helpers for the registered N:1 channel mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package muxn_pkg;

  // Channel selection policy.
  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_t;

  // Index width for n items.
  // Never returns less than 1, so a vector declared from it is never zero-width.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muxn_rr_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : muxn_rr_reg_if
//  Description : Producer/consumer bundle for muxn_rr_reg. The slave side is
//                the mux. The master side is the environment that drives the
//                N producers and the single consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muxn_rr_reg_if
  import muxn_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = clog2_min1(N);

  mux_mode_t              mode;
  logic [SELW-1:0]        sel;
  logic [N-1:0]           I_valid;
  logic [N-1:0]           I_ready;
  logic [N*WIDTH-1:0]     I_data;
  logic                   O_valid;
  logic                   O_ready;
  logic [WIDTH-1:0]       O_data;
  logic [SELW-1:0]        O_chan;

  modport slave (
    input  mode, sel, I_valid, I_data, O_ready,
    output I_ready, O_valid, O_data, O_chan
  );

  modport master (
    output mode, sel, I_valid, I_data, O_ready,
    input  I_ready, O_valid, O_data, O_chan
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_n
//  Description : Combinational round-robin pick. It searches the request
//                vector starting one past last_grant and wraps modulo N. The
//                pointer register is held by the caller.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_n
  import muxn_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last_grant,
  output logic            grant_valid,
  output logic [SELW-1:0] grant
);

  // Scan from the farthest offset down to the nearest one.
  // The last hit is therefore the closest requester after last_grant.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant       = SELW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muxn_rr_reg.sv
`default_nettype none
// ============================================================================
//  Module      : muxn_rr_reg
//  Description : Registered N:1 channel mux with valid/ready on every side.
//                A channel is chosen by explicit select or by round-robin.
//                The winner is loaded into a one-entry output stage, which
//                sustains one transfer per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module muxn_rr_reg
  import muxn_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  muxn_rr_reg_if.slave       bus
);
  localparam int SELW = clog2_min1(N);

  logic              load_en;
  logic              grant_valid;
  logic [SELW-1:0]   grant;
  logic              rr_valid;
  logic [SELW-1:0]   rr_grant;
  logic [SELW-1:0]   last_grant;
  logic [WIDTH-1:0]  sel_data;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [SELW-1:0]   out_chan;

  // The output stage can take a new word when it is empty or being drained.
  assign load_en = !out_valid || bus.O_ready;

  rr_arbiter_n #(.N(N), .SELW(SELW)) u_arb (
    .req         (bus.I_valid),
    .last_grant  (last_grant),
    .grant_valid (rr_valid),
    .grant       (rr_grant)
  );

  // Choose the winner for this cycle.
  // In fixed mode an out-of-range select matches no channel, so nothing is granted.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    if (bus.mode == MUX_RR) begin
      grant_valid = rr_valid;
      grant       = rr_grant;
    end else begin
      for (int i = 0; i < N; i++) begin
        if ((int'(bus.sel) == i) && bus.I_valid[i]) begin
          grant_valid = 1'b1;
          grant       = SELW'(i);
        end
      end
    end
  end

  // One-hot ready to the winning producer.
  // Held low while reset is asserted.
  always_comb begin
    bus.I_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.I_ready[i] = ASYNCRESETN && load_en && grant_valid && (grant == SELW'(i));
    end
  end

  // Pick the winning channel's slice out of the packed data bus.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        sel_data = bus.I_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage and round-robin pointer.
  // The pointer starts at N-1 so that the first round-robin grant after reset goes to channel 0.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      last_grant <= SELW'(N - 1);
    end else if (load_en) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= sel_data;
        out_chan <= grant;
        if (bus.mode == MUX_RR) begin
          last_grant <= grant;
        end
      end
    end
  end

  assign bus.O_valid = out_valid;
  assign bus.O_data  = out_data;
  assign bus.O_chan  = out_chan;

endmodule
`default_nettype wire
